uart_cmd_wrapper: RTL and testbench
===================================

Name: uart_cmd_wrapper

Overview:
Sits between the UART byte transceiver and the command processor. Assembles two received bytes (high byte first) into a 16-bit command and holds it with a cmd_rdy/clr_cmd_rdy handshake. Sends a single-byte acknowledge through the UART transmitter whenever the command processor pulses send_resp. An inter-byte timeout discards a stranded high byte so the host can resynchronise.

Parameters:
TMO_W, 16, width of the inter-byte timeout counter
TMO_CYC, 16'd50000, clk cycles allowed between high byte and low byte before the frame is discarded
RESP_BYTE, 8'hA5, byte transmitted as the acknowledge

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_rdy  in  1  UART receiver has a byte in rx_data; level, held until cleared
rx_data  in  8  received byte, valid while rx_rdy=1
clr_rx_rdy  out  1  one-cycle pulse acknowledging the current rx byte
cmd  out  16  assembled command {high byte, low byte}
cmd_rdy  out  1  cmd valid; level, held until cleared
clr_cmd_rdy  in  1  command processor consumed cmd
send_resp  in  1  one-cycle request to transmit RESP_BYTE
trmt  out  1  one-cycle pulse starting a UART transmission
tx_data  out  8  byte to transmit; constant RESP_BYTE
tx_done  in  1  UART transmitter finished the current byte (pulse)
resp_sent  out  1  one-cycle pulse when the acknowledge byte completes
frm_err  out  1  one-cycle pulse when a frame times out

Behaviour:
- Reset values: clr_rx_rdy=0, cmd=16'h0000, cmd_rdy=0, trmt=0, resp_sent=0, frm_err=0, hi_byte register=8'h00, timeout counter=0, RX FSM=RX_HI, TX FSM=TX_IDLE, pend=0. tx_data=RESP_BYTE at all times.
- RX FSM, states RX_HI and RX_LO:
  - RX_HI, rx_rdy=1: hi_byte<=rx_data; clr_rx_rdy=1 (combinational, same cycle); cmd_rdy<=0 (new frame supersedes the unconsumed command); counter<=0; go to RX_LO.
  - RX_LO, rx_rdy=1: cmd<={hi_byte, rx_data}; cmd_rdy<=1 the next edge, so cmd_rdy is visible 1 cycle after the low byte is accepted; clr_rx_rdy=1; go to RX_HI.
  - RX_LO, rx_rdy=0: counter increments. When counter==TMO_CYC-1 and rx_rdy=0: frm_err=1 for one cycle; go to RX_HI; cmd and cmd_rdy unchanged.
  - A byte arriving in the same cycle as the timeout terminal count is accepted as the low byte. It does not time out.
- cmd changes only on low-byte acceptance and is stable while cmd_rdy=1.
- cmd_rdy priority: set (low-byte accept) > clear (RX_HI accept) > clr_cmd_rdy. clr_cmd_rdy while cmd_rdy=0 has no effect.
- TX FSM, states TX_IDLE and TX_BUSY:
  - TX_IDLE with send_resp=1 or pend=1: trmt=1 for one cycle; pend<=0; go to TX_BUSY.
  - TX_BUSY: send_resp=1 sets pend<=1. Only one pending request is held; further requests while pend=1 are dropped.
  - TX_BUSY, tx_done=1: resp_sent=1 for one cycle; go to TX_IDLE. A pending request issues trmt on the following cycle.
  - send_resp and tx_done in the same cycle while in TX_BUSY: pend<=1 and resp_sent=1 both happen.
- RX and TX paths are independent and may be active in the same cycle.
- rst_n assertion mid-frame or mid-transmit returns all state to reset values immediately. A partial frame is lost. No trmt is issued after reset until a new send_resp arrives.

Test Plan:
- Bytes 8'h25 then 8'h4F, each held on rx_rdy until clr_rx_rdy -> two clr_rx_rdy pulses; cmd=16'h254F; cmd_rdy=1 one cycle after the second pulse; it stays 1 until clr_cmd_rdy, then 0.
- High byte 8'h40, then no rx_rdy for TMO_CYC cycles (use TMO_CYC=20) -> frm_err pulse at cycle 20; previous cmd unchanged. The next bytes 8'h60 and 8'h00 give cmd=16'h6000.
- Low byte presented exactly at the terminal-count cycle -> accepted; frm_err stays 0; cmd_rdy=1.
- cmd_rdy=1 with 16'h254F unconsumed, then new high byte 8'h01 -> cmd_rdy drops the cycle after acceptance; cmd still 16'h254F until the low byte 8'h02 gives 16'h0102.
- send_resp pulse -> trmt pulse the same cycle, tx_data=8'hA5. tx_done 10 cycles later -> resp_sent pulse. A second send_resp during busy -> second trmt the cycle after tx_done.
- Three send_resp pulses during one busy period -> exactly two trmt pulses in total. rst_n low mid-transmit -> no further trmt or resp_sent.

Source files
------------

// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper
//   Glue between the UART byte transceiver and the command processor.
//   Receive side: two bytes (high first) are packed into a 16-bit command,
//   presented with a level cmd_rdy that the processor clears. If the low
//   byte does not arrive within TMO_CYC cycles of the high byte, the
//   stranded high byte is dropped and frm_err pulses so the host can
//   resynchronise.
//   Transmit side: each send_resp pulse sends RESP_BYTE once; a single
//   request arriving while a byte is in flight is remembered and sent next.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   i_rx_rdy       receiver holds a byte in i_rx_data (level)
//   i_rx_data      received byte
//   o_clr_rx_rdy   one-cycle acknowledge of the current rx byte
//   o_cmd          assembled command {high, low}
//   o_cmd_rdy      o_cmd valid (level, until i_clr_cmd_rdy)
//   i_clr_cmd_rdy  command processor consumed o_cmd
//   i_send_resp    one-cycle request to transmit RESP_BYTE
//   o_trmt         one-cycle pulse starting a UART transmission
//   o_tx_data      byte to transmit (always RESP_BYTE)
//   i_tx_done      transmitter finished the current byte (pulse)
//   o_resp_sent    one-cycle pulse when the acknowledge byte completes
//   o_frm_err      one-cycle pulse when a frame times out
module uart_cmd_wrapper #(
  parameter int unsigned      TMO_W     = 16,
  parameter logic [TMO_W-1:0] TMO_CYC   = 16'd50000,
  parameter logic [7:0]       RESP_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rx_rdy,
  input  logic [7:0]  i_rx_data,
  output logic        o_clr_rx_rdy,
  output logic [15:0] o_cmd,
  output logic        o_cmd_rdy,
  input  logic        i_clr_cmd_rdy,
  input  logic        i_send_resp,
  output logic        o_trmt,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_done,
  output logic        o_resp_sent,
  output logic        o_frm_err
);

  // Counter value of the last cycle the low byte may still arrive in.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - TMO_W'(1);

  typedef enum logic {RX_HI, RX_LO} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  rx_state_t        r_rx_state;
  rx_state_t        w_rx_state_nxt;
  logic [7:0]       r_hi_byte;
  logic [7:0]       w_hi_byte_nxt;
  logic [15:0]      r_cmd;
  logic [15:0]      w_cmd_nxt;
  logic             r_cmd_rdy;
  logic             w_cmd_rdy_nxt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [TMO_W-1:0] w_tmo_cnt_nxt;
  logic             w_clr_rx_rdy;
  logic             w_frm_err;

  tx_state_t        r_tx_state;
  tx_state_t        w_tx_state_nxt;
  logic             r_pend;
  logic             w_pend_nxt;
  logic             w_trmt;
  logic             w_resp_sent;

  // State registers for both paths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_HI;
      r_hi_byte  <= 8'h00;
      r_cmd      <= 16'h0000;
      r_cmd_rdy  <= 1'b0;
      r_tmo_cnt  <= '0;
      r_tx_state <= TX_IDLE;
      r_pend     <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_hi_byte  <= w_hi_byte_nxt;
      r_cmd      <= w_cmd_nxt;
      r_cmd_rdy  <= w_cmd_rdy_nxt;
      r_tmo_cnt  <= w_tmo_cnt_nxt;
      r_tx_state <= w_tx_state_nxt;
      r_pend     <= w_pend_nxt;
    end
  end

  // Receive FSM. cmd_rdy updates are ordered lowest priority first so the
  // later assignment wins: consumer clear < new-frame clear < low-byte set.
  // A low byte in the terminal-count cycle is taken before the timeout test.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_hi_byte_nxt  = r_hi_byte;
    w_cmd_nxt      = r_cmd;
    w_cmd_rdy_nxt  = r_cmd_rdy;
    w_tmo_cnt_nxt  = r_tmo_cnt;
    w_clr_rx_rdy   = 1'b0;
    w_frm_err      = 1'b0;

    if (i_clr_cmd_rdy) begin
      w_cmd_rdy_nxt = 1'b0;
    end

    case (r_rx_state)
      RX_HI: begin
        if (i_rx_rdy) begin
          w_hi_byte_nxt  = i_rx_data;
          w_clr_rx_rdy   = 1'b1;
          w_cmd_rdy_nxt  = 1'b0;
          w_tmo_cnt_nxt  = '0;
          w_rx_state_nxt = RX_LO;
        end
      end
      RX_LO: begin
        if (i_rx_rdy) begin
          w_cmd_nxt      = {r_hi_byte, i_rx_data};
          w_cmd_rdy_nxt  = 1'b1;
          w_clr_rx_rdy   = 1'b1;
          w_rx_state_nxt = RX_HI;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_frm_err      = 1'b1;
          w_rx_state_nxt = RX_HI;
        end else begin
          w_tmo_cnt_nxt  = r_tmo_cnt + TMO_W'(1);
        end
      end
      default: w_rx_state_nxt = RX_HI;
    endcase
  end

  // Transmit FSM. Only one request is buffered while busy; extras are lost.
  // A request buffered in the tx_done cycle starts on the next cycle.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_pend_nxt     = r_pend;
    w_trmt         = 1'b0;
    w_resp_sent    = 1'b0;

    case (r_tx_state)
      TX_IDLE: begin
        if (i_send_resp || r_pend) begin
          w_trmt         = 1'b1;
          w_pend_nxt     = 1'b0;
          w_tx_state_nxt = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (i_send_resp) begin
          w_pend_nxt = 1'b1;
        end
        if (i_tx_done) begin
          w_resp_sent    = 1'b1;
          w_tx_state_nxt = TX_IDLE;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  assign o_clr_rx_rdy = w_clr_rx_rdy;
  assign o_frm_err    = w_frm_err;
  assign o_cmd        = r_cmd;
  assign o_cmd_rdy    = r_cmd_rdy;
  assign o_trmt       = w_trmt;
  assign o_resp_sent  = w_resp_sent;
  assign o_tx_data    = RESP_BYTE;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb_uart_cmd_wrapper
//   Self-checking bench for uart_cmd_wrapper with a short timeout
//   (TMO_CYC = 20). A table of one-cycle vectors covers frame assembly,
//   cmd_rdy handshake/priority and basic transmit handshakes; hand-written
//   sequences cover the timeout, terminal-count acceptance, pending
//   transmit requests and reset in the middle of activity.
module tb_uart_cmd_wrapper;

   logic        clk;
   logic        rstN;
   logic        rxRdy;
   logic [7:0]  rxData;
   logic        clrRxRdy;
   logic [15:0] cmd;
   logic        cmdRdy;
   logic        clrCmdRdy;
   logic        sendResp;
   logic        trmt;
   logic [7:0]  txData;
   logic        txDone;
   logic        respSent;
   logic        frmErr;

   int nChecks = 0;
   int nErrors = 0;

   typedef struct {
      logic        rxRdy;
      logic [7:0]  rxData;
      logic        clrCmdRdy;
      logic        sendResp;
      logic        txDone;
      logic        expClrRx;
      logic [15:0] expCmd;
      logic        expCmdRdy;
      logic        expTrmt;
      logic        expRespSent;
      logic        expFrmErr;
   } vec_t;

   vec_t vecs[$];

   uart_cmd_wrapper #(
      .TMO_W    (16),
      .TMO_CYC  (16'd20),
      .RESP_BYTE(8'hA5)
   ) dut (
      .clk          (clk),
      .rst_n        (rstN),
      .i_rx_rdy     (rxRdy),
      .i_rx_data    (rxData),
      .o_clr_rx_rdy (clrRxRdy),
      .o_cmd        (cmd),
      .o_cmd_rdy    (cmdRdy),
      .i_clr_cmd_rdy(clrCmdRdy),
      .i_send_resp  (sendResp),
      .o_trmt       (trmt),
      .o_tx_data    (txData),
      .i_tx_done    (txDone),
      .o_resp_sent  (respSent),
      .o_frm_err    (frmErr)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs just after the rising edge, then move to
   // the falling edge where outputs are sampled.
   task automatic applyStimulus(input logic r, input logic [7:0] d,
                                input logic c, input logic s, input logic t);
      @(posedge clk);
      #1;
      rxRdy     = r;
      rxData    = d;
      clrCmdRdy = c;
      sendResp  = s;
      txDone    = t;
      @(negedge clk);
   endtask

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string name, input logic [15:0] act,
                              input logic [15:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mkVec(input logic r, input logic [7:0] d,
                                  input logic c, input logic s, input logic t,
                                  input logic eClr, input logic [15:0] eCmd,
                                  input logic eRdy, input logic eTrmt,
                                  input logic eRs, input logic eFe);
      vec_t v;
      v.rxRdy = r; v.rxData = d; v.clrCmdRdy = c; v.sendResp = s; v.txDone = t;
      v.expClrRx = eClr; v.expCmd = eCmd; v.expCmdRdy = eRdy;
      v.expTrmt = eTrmt; v.expRespSent = eRs; v.expFrmErr = eFe;
      return v;
   endfunction

   initial begin
      int trmtCount;
      int rsCount;

      // Columns: rxRdy rxData clrCmd send done | clrRx cmd cmdRdy trmt rs frmErr
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 0,  0, 16'h0000, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 8'h25, 0, 0, 0,  1, 16'h0000, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 0,  0, 16'h0000, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 8'h4F, 0, 0, 0,  1, 16'h0000, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 0,  0, 16'h254F, 1, 0, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 0,  0, 16'h254F, 1, 0, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 1, 0, 0,  0, 16'h254F, 1, 0, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 0,  0, 16'h254F, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 1, 0, 0,  0, 16'h254F, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 8'h25, 0, 0, 0,  1, 16'h254F, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 8'h4F, 0, 0, 0,  1, 16'h254F, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 0,  0, 16'h254F, 1, 0, 0, 0));
      // New high byte supersedes the unconsumed command.
      vecs.push_back(mkVec(1, 8'h01, 0, 0, 0,  1, 16'h254F, 1, 0, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 0,  0, 16'h254F, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 8'h02, 0, 0, 0,  1, 16'h254F, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 0,  0, 16'h0102, 1, 0, 0, 0));
      // Low-byte set beats a simultaneous consumer clear.
      vecs.push_back(mkVec(1, 8'h11, 0, 0, 0,  1, 16'h0102, 1, 0, 0, 0));
      vecs.push_back(mkVec(1, 8'h22, 1, 0, 0,  1, 16'h0102, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 0,  0, 16'h1122, 1, 0, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 1, 0, 0,  0, 16'h1122, 1, 0, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 0,  0, 16'h1122, 0, 0, 0, 0));
      // Transmit: start, pending request, done+request in the same cycle.
      vecs.push_back(mkVec(0, 8'h00, 0, 1, 0,  0, 16'h1122, 0, 1, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 0,  0, 16'h1122, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 1, 0,  0, 16'h1122, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 1,  0, 16'h1122, 0, 0, 1, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 0,  0, 16'h1122, 0, 1, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 1, 1,  0, 16'h1122, 0, 0, 1, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 0,  0, 16'h1122, 0, 1, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 1,  0, 16'h1122, 0, 0, 1, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 0,  0, 16'h1122, 0, 0, 0, 0));
      // RX and TX active in the same cycles.
      vecs.push_back(mkVec(1, 8'h33, 0, 1, 0,  1, 16'h1122, 0, 1, 0, 0));
      vecs.push_back(mkVec(1, 8'h44, 0, 0, 1,  1, 16'h1122, 0, 0, 1, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 0,  0, 16'h3344, 1, 0, 0, 0));

      // Reset with quiet inputs; outputs must sit at reset values.
      rstN = 1'b0; rxRdy = 1'b0; rxData = 8'h00; clrCmdRdy = 1'b0;
      sendResp = 1'b0; txDone = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset cmd",      cmd,                16'h0000);
      checkOutput("reset cmd_rdy",  {15'd0, cmdRdy},    16'd0);
      checkOutput("reset trmt",     {15'd0, trmt},      16'd0);
      checkOutput("reset resp",     {15'd0, respSent},  16'd0);
      checkOutput("reset frm_err",  {15'd0, frmErr},    16'd0);
      checkOutput("reset clr_rx",   {15'd0, clrRxRdy},  16'd0);
      checkOutput("reset tx_data",  {8'd0, txData},     16'h00A5);
      @(posedge clk);
      #1 rstN = 1'b1;

      // Table-driven vectors.
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rxRdy, vecs[i].rxData, vecs[i].clrCmdRdy,
                       vecs[i].sendResp, vecs[i].txDone);
         checkOutput($sformatf("vec%0d clr_rx", i),  {15'd0, clrRxRdy}, {15'd0, vecs[i].expClrRx});
         checkOutput($sformatf("vec%0d cmd", i),     cmd,               vecs[i].expCmd);
         checkOutput($sformatf("vec%0d cmd_rdy", i), {15'd0, cmdRdy},   {15'd0, vecs[i].expCmdRdy});
         checkOutput($sformatf("vec%0d trmt", i),    {15'd0, trmt},     {15'd0, vecs[i].expTrmt});
         checkOutput($sformatf("vec%0d resp", i),    {15'd0, respSent}, {15'd0, vecs[i].expRespSent});
         checkOutput($sformatf("vec%0d frm_err", i), {15'd0, frmErr},   {15'd0, vecs[i].expFrmErr});
      end

      // Timeout: high byte 40 then silence; frm_err on the 20th idle cycle.
      applyStimulus(1, 8'h40, 0, 0, 0);
      checkOutput("tmo hi clr_rx", {15'd0, clrRxRdy}, 16'd1);
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(0, 8'h00, 0, 0, 0);
         checkOutput($sformatf("tmo cyc%0d frm_err", i), {15'd0, frmErr},
                     (i == 20) ? 16'd1 : 16'd0);
      end
      applyStimulus(0, 8'h00, 0, 0, 0);
      checkOutput("tmo after frm_err", {15'd0, frmErr}, 16'd0);
      checkOutput("tmo cmd kept",      cmd,              16'h3344);
      checkOutput("tmo cmd_rdy",       {15'd0, cmdRdy},  16'd0);
      applyStimulus(1, 8'h60, 0, 0, 0);
      checkOutput("resync hi clr_rx", {15'd0, clrRxRdy}, 16'd1);
      applyStimulus(1, 8'h00, 0, 0, 0);
      checkOutput("resync lo clr_rx", {15'd0, clrRxRdy}, 16'd1);
      applyStimulus(0, 8'h00, 0, 0, 0);
      checkOutput("resync cmd",     cmd,             16'h6000);
      checkOutput("resync cmd_rdy", {15'd0, cmdRdy}, 16'd1);

      // Low byte in the terminal-count cycle is accepted, no frm_err.
      applyStimulus(1, 8'hAB, 0, 0, 0);
      for (int i = 1; i <= 19; i++) applyStimulus(0, 8'h00, 0, 0, 0);
      applyStimulus(1, 8'hCD, 0, 0, 0);
      checkOutput("tc frm_err", {15'd0, frmErr},   16'd0);
      checkOutput("tc clr_rx",  {15'd0, clrRxRdy}, 16'd1);
      applyStimulus(0, 8'h00, 0, 0, 0);
      checkOutput("tc cmd",         cmd,              16'hABCD);
      checkOutput("tc cmd_rdy",     {15'd0, cmdRdy},  16'd1);
      checkOutput("tc frm_err late", {15'd0, frmErr}, 16'd0);

      // Transmit with a 10-cycle busy period and one request while busy.
      for (int c = 0; c <= 22; c++) begin
         applyStimulus(0, 8'h00, 0, (c == 0 || c == 5), (c == 10 || c == 21));
         checkOutput($sformatf("tx c%0d trmt", c), {15'd0, trmt},
                     (c == 0 || c == 11) ? 16'd1 : 16'd0);
         checkOutput($sformatf("tx c%0d resp", c), {15'd0, respSent},
                     (c == 10 || c == 21) ? 16'd1 : 16'd0);
         if (c == 0) checkOutput("tx tx_data", {8'd0, txData}, 16'h00A5);
      end

      // Three requests in one busy period give exactly two transmissions.
      trmtCount = 0;
      rsCount   = 0;
      for (int c = 0; c <= 12; c++) begin
         applyStimulus(0, 8'h00, 0, (c == 0 || c == 2 || c == 3 || c == 4),
                       (c == 6 || c == 9));
         if (trmt)     trmtCount++;
         if (respSent) rsCount++;
      end
      checkOutput("multi trmt count", 16'(trmtCount), 16'd2);
      checkOutput("multi resp count", 16'(rsCount),   16'd2);

      // Reset mid-transmit with a pending request and a stranded high byte.
      applyStimulus(1, 8'h77, 0, 1, 0);
      checkOutput("pre-rst trmt", {15'd0, trmt}, 16'd1);
      applyStimulus(0, 8'h00, 0, 1, 0);
      @(posedge clk);
      #1;
      sendResp = 1'b0;
      #1;
      rstN = 1'b0;
      #2;
      checkOutput("in-rst cmd",     cmd,             16'h0000);
      checkOutput("in-rst cmd_rdy", {15'd0, cmdRdy}, 16'd0);
      @(posedge clk);
      #1 rstN = 1'b1;
      trmtCount = 0;
      rsCount   = 0;
      for (int c = 0; c <= 9; c++) begin
         applyStimulus(0, 8'h00, 0, 0, (c == 3));
         if (trmt)     trmtCount++;
         if (respSent) rsCount++;
      end
      checkOutput("post-rst trmt count", 16'(trmtCount), 16'd0);
      checkOutput("post-rst resp count", 16'(rsCount),   16'd0);
      applyStimulus(1, 8'h12, 0, 0, 0);
      applyStimulus(1, 8'h34, 0, 0, 0);
      applyStimulus(0, 8'h00, 0, 0, 0);
      checkOutput("post-rst cmd",     cmd,             16'h1234);
      checkOutput("post-rst cmd_rdy", {15'd0, cmdRdy}, 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
